// File: rtl/mult_wb_sched_pkg.sv
// Shared constants for the multiply issue scheduler:
// stall-cause encodings and default widths.
package mult_wb_sched_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int MULT_LAT_DEF = 5;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_RAW  = 2'd1,
        STALL_WAW  = 2'd2,
        STALL_PORT = 2'd3
    } stall_e;

endpackage

// File: rtl/mult_wb_sched_track_sr.sv
// Valid/destination shift register for in-flight multiplies,
// with per-entry compare ports. Bit k-1 represents entry k.
module mult_track_sr
    import mult_wb_sched_pkg::*;
#(
    parameter int LAT = MULT_LAT_DEF,
    parameter int AW  = REG_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_push,
    input  logic [AW-1:0]  i_push_dst,
    input  logic [AW-1:0]  i_src_a,
    input  logic [AW-1:0]  i_src_b,
    input  logic [AW-1:0]  i_dst,
    output logic [LAT-1:0] o_hit_a,
    output logic [LAT-1:0] o_hit_b,
    output logic [LAT-1:0] o_hit_d,
    output logic [LAT-1:0] o_pv,
    output logic           o_pv_pen,
    output logic           o_pv_last
);

    logic [LAT-1:0] r_pv;
    logic [AW-1:0]  r_pd [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int k = 0; k < LAT; k++) r_pd[k] <= '0;
        end else begin
            r_pv    <= {r_pv[LAT-2:0], i_push};
            r_pd[0] <= i_push_dst;
            for (int k = 1; k < LAT; k++) r_pd[k] <= r_pd[k-1];
        end
    end

    // Register 0 is hard-wired, so it never creates a dependency.
    always_comb begin
        o_hit_a = '0;
        o_hit_b = '0;
        o_hit_d = '0;
        for (int k = 0; k < LAT; k++) begin
            o_hit_a[k] = r_pv[k] && (r_pd[k] == i_src_a) && (i_src_a != '0);
            o_hit_b[k] = r_pv[k] && (r_pd[k] == i_src_b) && (i_src_b != '0);
            o_hit_d[k] = r_pv[k] && (r_pd[k] == i_dst) && (i_dst != '0);
        end
    end

    assign o_pv      = r_pv;
    assign o_pv_pen  = r_pv[LAT-2];
    assign o_pv_last = r_pv[LAT-1];

endmodule

// File: rtl/mult_wb_sched.sv
// Issue-side hazard scheduler for the multi-cycle multiplier and
// the shared regfile write port.
module mult_wb_sched
    import mult_wb_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int REG_ADDR = REG_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_is_mult,
    input  logic                issue_regwrite,
    input  logic [REG_ADDR-1:0] issue_dst,
    input  logic                issue_use_a,
    input  logic                issue_use_b,
    input  logic [REG_ADDR-1:0] issue_src_a,
    input  logic [REG_ADDR-1:0] issue_src_b,
    output logic                stall,
    output logic [1:0]          stall_cause,
    output logic                mult_launch,
    output logic                wb_sel_mult,
    output logic [2:0]          inflight,
    output logic                busy
);

    logic [MULT_LAT-1:0] w_hit_a;
    logic [MULT_LAT-1:0] w_hit_b;
    logic [MULT_LAT-1:0] w_hit_d;
    logic [MULT_LAT-1:0] w_pv;
    logic                w_pv_pen;
    logic                w_pv_last;
    logic                w_raw;
    logic                w_waw;
    logic                w_port;
    logic                w_acc;
    logic                w_push;
    logic [2:0]          w_cnt;

    mult_track_sr #(
        .LAT (MULT_LAT),
        .AW  (REG_ADDR)
    ) u_track (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dst (issue_dst),
        .i_src_a    (issue_src_a),
        .i_src_b    (issue_src_b),
        .i_dst      (issue_dst),
        .o_hit_a    (w_hit_a),
        .o_hit_b    (w_hit_b),
        .o_hit_d    (w_hit_d),
        .o_pv       (w_pv),
        .o_pv_pen   (w_pv_pen),
        .o_pv_last  (w_pv_last)
    );

    assign w_raw  = (issue_use_a && (|w_hit_a)) ||
                    (issue_use_b && (|w_hit_b));
    assign w_waw  = issue_regwrite && (|w_hit_d);
    // An ALU write would collide with the multiply retiring next cycle.
    assign w_port = !issue_is_mult && issue_regwrite && w_pv_pen;

    assign stall  = issue_valid && (w_raw || w_waw || w_port);
    assign w_acc  = issue_valid && !stall;
    assign w_push = w_acc && issue_is_mult && issue_regwrite;

    always_comb begin
        stall_cause = STALL_NONE;
        if (issue_valid) begin
            priority case (1'b1)
                w_raw:   stall_cause = STALL_RAW;
                w_waw:   stall_cause = STALL_WAW;
                w_port:  stall_cause = STALL_PORT;
                default: stall_cause = STALL_NONE;
            endcase
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < MULT_LAT; k++) begin
            w_cnt = w_cnt + {2'b00, w_pv[k]};
        end
    end

    assign mult_launch = w_acc && issue_is_mult;
    assign wb_sel_mult = w_pv_last;
    assign inflight    = w_cnt;
    assign busy        = (w_cnt != 3'd0);

endmodule

// File: tb/tb_mult_wb_sched.sv
// Directed table-driven bench for mult_wb_sched, plus an
// asynchronous mid-stream reset sequence.
module tb_mult_wb_sched;
    import mult_wb_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_is_mult;
    logic       issue_regwrite;
    logic [4:0] issue_dst;
    logic       issue_use_a;
    logic       issue_use_b;
    logic [4:0] issue_src_a;
    logic [4:0] issue_src_b;
    logic       stall;
    logic [1:0] stall_cause;
    logic       mult_launch;
    logic       wb_sel_mult;
    logic [2:0] inflight;
    logic       busy;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic       v;
        logic       m;
        logic       w;
        logic [4:0] d;
        logic       ua;
        logic [4:0] sa;
        logic       ub;
        logic [4:0] sb;
        logic       st;
        logic [1:0] c;
        logic       la;
        logic       wb;
        logic [2:0] inf;
    } vec_t;

    vec_t tbl[$];

    mult_wb_sched dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_is_mult  (issue_is_mult),
        .issue_regwrite (issue_regwrite),
        .issue_dst      (issue_dst),
        .issue_use_a    (issue_use_a),
        .issue_use_b    (issue_use_b),
        .issue_src_a    (issue_src_a),
        .issue_src_b    (issue_src_b),
        .stall          (stall),
        .stall_cause    (stall_cause),
        .mult_launch    (mult_launch),
        .wb_sel_mult    (wb_sel_mult),
        .inflight       (inflight),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input int v, input int m, input int w, input int d,
        input int ua, input int sa, input int ub, input int sb,
        input int st, input int c, input int la, input int wb,
        input int inf
    );
        vec_t x;
        x.v = 1'(v);  x.m = 1'(m);   x.w = 1'(w);   x.d = 5'(d);
        x.ua = 1'(ua); x.sa = 5'(sa); x.ub = 1'(ub); x.sb = 5'(sb);
        x.st = 1'(st); x.c = 2'(c);   x.la = 1'(la); x.wb = 1'(wb);
        x.inf = 3'(inf);
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0d want %0d", n, got, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        issue_valid    = x.v;
        issue_is_mult  = x.m;
        issue_regwrite = x.w;
        issue_dst      = x.d;
        issue_use_a    = x.ua;
        issue_src_a    = x.sa;
        issue_use_b    = x.ub;
        issue_src_b    = x.sb;
    endtask

    task automatic idle_in();
        drive(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    endtask

    task automatic chk_all(input string n, input vec_t x);
        chk({n, " stall"}, 32'(stall), 32'(x.st));
        chk({n, " cause"}, 32'(stall_cause), 32'(x.c));
        chk({n, " launch"}, 32'(mult_launch), 32'(x.la));
        chk({n, " wbsel"}, 32'(wb_sel_mult), 32'(x.wb));
        chk({n, " inflight"}, 32'(inflight), 32'(x.inf));
        chk({n, " busy"}, 32'(busy), 32'(x.inf != 3'd0));
    endtask

    initial begin
        // RAW: mul r3, dependent mul then add stall through t+5
        tbl.push_back(mk(1,1,1,3, 0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1,1,1,4, 1,3,0,0, 1,1,0,0,1));
        tbl.push_back(mk(1,0,1,4, 1,3,1,1, 1,1,0,0,1));
        tbl.push_back(mk(1,0,1,4, 1,3,1,1, 1,1,0,0,1));
        tbl.push_back(mk(1,0,1,4, 1,3,1,1, 1,1,0,0,1));
        tbl.push_back(mk(1,0,1,4, 1,3,1,1, 1,1,0,1,1));
        tbl.push_back(mk(1,0,1,4, 1,3,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        // WAW: mul r7, addi r7 at t+2; port also true at t+4
        tbl.push_back(mk(1,1,1,7, 0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,0,1,7, 1,1,0,0, 1,2,0,0,1));
        tbl.push_back(mk(1,0,1,7, 1,1,0,0, 1,2,0,0,1));
        tbl.push_back(mk(1,0,1,7, 1,1,0,0, 1,2,0,0,1));
        tbl.push_back(mk(1,0,1,7, 1,1,0,0, 1,2,0,1,1));
        tbl.push_back(mk(1,0,1,7, 1,1,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        // Port: mul r2, independent add r9 at t+4
        tbl.push_back(mk(1,1,1,2, 0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,0,1,9, 1,1,1,5, 1,3,0,0,1));
        tbl.push_back(mk(1,0,1,9, 1,1,1,5, 0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        // Throughput, then retire+accept in the same cycle
        tbl.push_back(mk(1,1,1,10, 0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1,1,1,11, 0,0,0,0, 0,0,1,0,1));
        tbl.push_back(mk(1,1,1,12, 0,0,0,0, 0,0,1,0,2));
        tbl.push_back(mk(1,1,1,13, 0,0,0,0, 0,0,1,0,3));
        tbl.push_back(mk(1,1,1,14, 0,0,0,0, 0,0,1,0,4));
        tbl.push_back(mk(1,1,1,15, 0,0,0,0, 0,0,1,1,5));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,5));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,2));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        // r0 never matches; non-writing multiply is untracked
        tbl.push_back(mk(1,1,1,0, 0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(1,0,1,1, 1,0,1,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,6, 0,0,0,0, 0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,0,1,8, 1,6,1,6, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));

        rst = 1'b1;
        idle_in();
        #1;
        chk_all("reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk_all($sformatf("v%0d", i), tbl[i]);
        end

        // Mid-stream asynchronous reset with three multiplies in flight
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive(mk(1,1,1,i, 0,0,0,0, 0,0,1,0,0));
        end
        @(negedge clk);
        idle_in();
        #1;
        chk("pre_rst inflight", 32'(inflight), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst inflight", 32'(inflight), 32'd0);
        chk("async_rst wbsel", 32'(wb_sel_mult), 32'd0);
        chk("async_rst busy", 32'(busy), 32'd0);
        drive(mk(1,0,1,5, 1,1,1,2, 0,0,0,0,0));
        #1;
        chk("async_rst stall", 32'(stall), 32'd0);
        chk("async_rst launch", 32'(mult_launch), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1,1,1,1, 0,0,0,0, 0,0,1,0,0));
        #1;
        chk_all("post_rst", mk(1,1,1,1, 0,0,0,0, 0,0,1,0,0));
        @(negedge clk);
        idle_in();
        #1;
        chk("post_rst track", 32'(inflight), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mult_wb_sched.md
# mult_wb_sched

Issue-side scheduler for the multi-cycle multiply pipeline (M1..M5) and the shared register-file write port. It sits between decode and execute. It tracks every in-flight multiply destination and stalls decode on RAW, WAW and write-port conflicts against the single-cycle ALU path. It also drives the launch strobe into M1 and the writeback mux select.

## Interface
Parameters:
- `MULT_LAT`, default 5: multiply pipeline depth; result is written to the regfile at the end of cycle `MULT_LAT` after issue.
- `REG_ADDR`, default `` `REG_ADDR`` (5): register index width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `issue_valid`, in, 1: decode presents an instruction this cycle.
- `issue_is_mult`, in, 1: the presented instruction is a multiply.
- `issue_regwrite`, in, 1: the presented instruction writes a GPR.
- `issue_dst`, in, `REG_ADDR`: destination register.
- `issue_use_a`, `issue_use_b`, in, 1 each: source operand A/B is read.
- `issue_src_a`, `issue_src_b`, in, `REG_ADDR` each: source registers.
- `stall`, out, 1: decode must hold the presented instruction.
- `stall_cause`, out, 2: 0 none, 1 RAW, 2 WAW, 3 write port.
- `mult_launch`, out, 1: drives M1 `regwrite_mult_in` qualification; multiply accepted this cycle.
- `wb_sel_mult`, out, 1: regfile write mux selects the multiply result this cycle.
- `inflight`, out, 3: number of valid tracked multiplies, 0..`MULT_LAT`.
- `busy`, out, 1: `inflight != 0`.

## Operation
- Tracker: `MULT_LAT` entries `pv[k]` and `pd[k]`, k=1..`MULT_LAT`. Entry k holds a GPR-writing multiply issued k cycles ago. Each cycle every entry shifts k→k+1; entry `MULT_LAT` retires.
- Accept: `acc = issue_valid & ~stall`. When `acc & issue_is_mult & issue_regwrite`, the next cycle holds `pv[1]=1` and `pd[1]=issue_dst`. Otherwise it holds `pv[1]=0`.
- RAW: any used source equals `pd[k]` with `pv[k]`, k=1..`MULT_LAT`. No bypass; a match on entry `MULT_LAT` still stalls. Register 0 never matches.
- WAW: `issue_regwrite` and `issue_dst` (≠0) equals any valid `pd[k]`. This applies to both ALU and multiply issues and prevents out-of-order overwrite.
- Port: a non-multiply with `issue_regwrite` when `pv[MULT_LAT-1]` is set. The ALU result would write in the same cycle as that multiply; the multiply has priority.
- `stall = issue_valid & (RAW | WAW | port)`. `stall_cause` follows the priority RAW > WAW > port, and is 0 when there is no stall.
- `mult_launch = acc & issue_is_mult`. A multiply with `issue_regwrite=0` still launches but is not tracked.
- `wb_sel_mult = pv[MULT_LAT]`.
- `inflight` is the popcount of `pv`.

## Timing
- `stall`, `stall_cause` and `mult_launch` are combinational from the inputs and the tracker, within the same cycle.
- `wb_sel_mult` and `inflight` are combinational from registered state only.
- Multiply issued in cycle t: `pv[1]` is set in t+1 and `wb_sel_mult` is high in cycle t+`MULT_LAT`. A dependent instruction is first accepted in t+`MULT_LAT`+1.
- Reset clears all `pv`. Every output is then 0: `stall`, `stall_cause`, `mult_launch`, `wb_sel_mult`, `inflight`, `busy`. A later `issue_valid` produces outputs combinationally. Reset asserted mid-operation discards all in-flight tracking immediately; datapath flush is the owner's concern.
- Back-to-back independent multiplies are accepted every cycle, so `inflight` saturates at `MULT_LAT`.
- A retire and an accept in the same cycle are both honoured, with no conflict.

## Structure
- `define.v` gets the `STALL_NONE/RAW/WAW/PORT` encodings and the default `MULT_LAT`.
- One sub-module, `mult_track_sr`: the valid/dst shift register with `MULT_LAT` compare ports. It outputs a per-source match vector and `pv[MULT_LAT-1]`/`pv[MULT_LAT]`.
- Top-level: hazard logic, cause priority, popcount.

## Test plan
- Reset mid-stream, with 3 multiplies in flight and `rst` asserted between edges: the tracker clears asynchronously, `inflight`→0 and `wb_sel_mult`→0 without a clock.
- RAW: `mul r3` at t, then `add r4,r3,r1` presented from t+1. Required: `stall=1` and `stall_cause=1` for t+1..t+5, accepted at t+6, and `wb_sel_mult=1` at t+5.
- WAW: `mul r7` at t, then `addi r7` at t+2. Required: stall with cause 2 until t+5, accepted at t+6.
- Port: `mul r2` at t and independent `add r9` presented at t+4. Required: `stall=1`, cause 3, at t+4. The add is accepted at t+5, and `wb_sel_mult=1` at t+5.
- Throughput: 5 independent multiplies t..t+4. Required: `mult_launch=1` each cycle, `inflight`=5 at t+5, and `wb_sel_mult` high t+5..t+9.
- r0 and non-writing: `mul r0` followed by `add r1,r0,r0`, and a multiply with `issue_regwrite=0`. Required: no stalls, and `inflight` stays 0 for the non-writing multiply.
